// File: rtl/btn_event_ctrl.sv
// ---------------------------------------------------------------------------
// btn_event_ctrl
//
// Debounces N_BTN raw pushbutton levels and turns them into a clean level
// plus one-cycle event pulses (press, release, long press, auto-repeat).
// All timing is expressed in ticks of one shared prescaler (TICK_DIV clocks
// per tick), so every channel sees the same time base.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   defined   : a held button emits an rpt pulse every REP_MS ticks after
//               its long_press pulse.
//   undefined : rpt is tied to 0 and no repeat logic exists.
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   noisy          in   [N_BTN] raw asynchronous button levels, 1 = pressed
//   clean          out  [N_BTN] debounced level
//   press          out  [N_BTN] one-cycle pulse when clean rises
//   release_pulse  out  [N_BTN] one-cycle pulse when clean falls
//   long_press     out  [N_BTN] one-cycle pulse after LONG_MS ticks held
//   rpt            out  [N_BTN] one-cycle auto-repeat pulse
//
// All outputs are registered. A level change on the synchronized input
// always wins over a tick arriving in the same cycle; that tick is simply
// not counted for the channel.
// ---------------------------------------------------------------------------
module btn_event_ctrl #(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = 100_000,
  parameter int DEB_MS   = 10,
  parameter int LONG_MS  = 1000,
  parameter int REP_MS   = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] noisy,
  output logic [N_BTN-1:0] clean,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] rpt
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]   DEB_C   = 16'(DEB_MS);
  localparam logic [15:0]   LONG_C  = 16'(LONG_MS);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [15:0]   REP_C   = 16'(REP_MS);
`else
  localparam logic [15:0]   rep_unused = 16'(REP_MS);
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_DOWN = 3'd2,
    ST_HELD = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  // Two-flop synchronizer; only sync2 is ever looked at by the FSMs.
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
    end
  end

  // Shared prescaler: tick is high for the single cycle the count sits at
  // TICK_DIV-1.
  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        origin;   // 1: REL was entered from HELD, 0: from DOWN
    logic        s;
    logic        clean_r;
    logic        press_r;
    logic        rel_r;
    logic        long_r;

    assign s = sync2[i];

    // Saturating increment: a long hold never wraps back to a small count.
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

`ifdef BTN_AUTO_REPEAT_EN
    logic rpt_r;
    assign rpt[i] = rpt_r;
`else
    assign rpt[i] = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        origin  <= 1'b0;
        clean_r <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        long_r  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_r   <= 1'b0;
`endif
      end else begin
        press_r <= 1'b0;
        rel_r   <= 1'b0;
        long_r  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_r   <= 1'b0;
`endif
        case (state)
          ST_IDLE: begin
            if (s) begin
              state <= ST_ARM;
              cnt   <= '0;
            end
          end
          ST_ARM: begin
            if (!s) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == DEB_C) begin
                state   <= ST_DOWN;
                cnt     <= '0;
                clean_r <= 1'b1;
                press_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          ST_DOWN: begin
            if (!s) begin
              state  <= ST_REL;
              cnt    <= '0;
              origin <= 1'b0;
            end else if (tick) begin
              if (cnt_inc == LONG_C) begin
                state  <= ST_HELD;
                cnt    <= '0;
                long_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          ST_HELD: begin
            if (!s) begin
              state  <= ST_REL;
              cnt    <= '0;
              origin <= 1'b1;
            end else if (tick) begin
`ifdef BTN_AUTO_REPEAT_EN
              if (cnt_inc == REP_C) begin
                cnt   <= '0;
                rpt_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
`else
              cnt <= cnt_inc;
`endif
            end
          end
          ST_REL: begin
            // A bounce back to 1 resumes the phase the press was in,
            // with its timer restarted; clean never drops.
            if (s) begin
              state <= origin ? ST_HELD : ST_DOWN;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == DEB_C) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                clean_r <= 1'b0;
                rel_r   <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign clean[i]         = clean_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = rel_r;
    assign long_press[i]    = long_r;
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_event_ctrl
//
// Bench for btn_event_ctrl with small timing parameters. A reference model
// built around "ticks since the synchronized level last changed" predicts
// every output every cycle. A table of input windows with hand-derived
// event counts, plus hand-written glitch, bounce and reset sequences, and a
// randomized phase, drive the design.
// ---------------------------------------------------------------------------
module tb_btn_event_ctrl;
  localparam int NB   = 4;
  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_IN_HOLD = 2;
`else
  localparam int RPT_IN_HOLD = 0;
`endif

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] noisy;
  logic [NB-1:0] clean, press, release_pulse, long_press, rpt;

  always #5 clock = ~clock;

  btn_event_ctrl #(
    .N_BTN(NB), .TICK_DIV(TD), .DEB_MS(DEB), .LONG_MS(LONG), .REP_MS(REP)
  ) dut (
    .clock(clock), .reset(reset), .noisy(noisy), .clean(clean),
    .press(press), .release_pulse(release_pulse),
    .long_press(long_press), .rpt(rpt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A channel's debounced level flips once DEB ticks have elapsed with the
  // synchronized level steadily different from it. While pressed, the time
  // measured from an anchor decides long press and repeat.
  logic [NB-1:0] m_sp1, m_sp2, m_sprev;
  logic [NB-1:0] m_clean, m_press, m_rel, m_long, m_rpt;
  int            m_stable [NB];
  int            m_base   [NB];
  bit            m_held   [NB];
  int            m_pre;

  logic [19:0] exp_q[$];

  // window statistics
  int            win_press, win_rel, win_long, win_rpt;
  logic [NB-1:0] win_clean_or;
  bit            saw_all_press;
  int            last_hi3, rel3_cyc, last_rst_cyc, press0_cyc;

  task automatic clear_win();
    win_press = 0; win_rel = 0; win_long = 0; win_rpt = 0;
    win_clean_or = '0; saw_all_press = 0;
  endtask

  task automatic model_step();
    bit tk;
    logic s;
    int e;
    if (reset) begin
      m_sp1 = '0; m_sp2 = '0; m_sprev = '0; m_pre = 0;
      m_clean = '0; m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
      for (int i = 0; i < NB; i++) begin
        m_stable[i] = 0; m_base[i] = 0; m_held[i] = 0;
      end
    end else begin
      tk = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
      m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
      for (int i = 0; i < NB; i++) begin
        s = m_sp2[i];
        if (s != m_sprev[i]) begin
          m_stable[i] = 0;
          m_base[i]   = 0;
        end else if (tk) begin
          m_stable[i]++;
          if (s != m_clean[i]) begin
            if (m_stable[i] == DEB) begin
              m_clean[i] = s;
              m_held[i]  = 0;
              if (s) begin
                m_press[i] = 1'b1;
                m_base[i]  = DEB;
              end else begin
                m_rel[i] = 1'b1;
              end
            end
          end else if (s) begin
            e = m_stable[i] - m_base[i];
            if (!m_held[i] && e == LONG) begin
              m_long[i] = 1'b1;
              m_held[i] = 1;
              m_base[i] = m_stable[i];
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (m_held[i] && (e % REP) == 0) begin
              m_rpt[i] = 1'b1;
            end
`endif
          end
        end
        m_sprev[i] = s;
      end
      m_sp2 = m_sp1;
      m_sp1 = noisy;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clock) begin
    logic [19:0] e;
    cyc++;
    model_step();
    exp_q.push_back({m_clean, m_press, m_rel, m_long, m_rpt});
    if (reset) last_rst_cyc = cyc;
    if (noisy[3]) last_hi3 = cyc;
    #1;
    e = exp_q.pop_front();
    check("clean", 32'(clean), 32'(e[19:16]));
    check("press", 32'(press), 32'(e[15:12]));
    check("release", 32'(release_pulse), 32'(e[11:8]));
    check("long_press", 32'(long_press), 32'(e[7:4]));
    check("rpt", 32'(rpt), 32'(e[3:0]));
    win_press += $countones(press);
    win_rel   += $countones(release_pulse);
    win_long  += $countones(long_press);
    win_rpt   += $countones(rpt);
    win_clean_or |= clean;
    if (press == 4'hF) saw_all_press = 1;
    if (release_pulse[3]) rel3_cyc = cyc;
    if (press[0] && press0_cyc < 0) press0_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic run_win(input logic [NB-1:0] nz, input int cycles);
    noisy = nz;
    repeat (cycles) @(negedge clock);
  endtask

  typedef struct {
    logic [NB-1:0] nz;
    int            cycles;
    logic [NB-1:0] exp_clean;
    int            exp_press;
    int            exp_rel;
    int            exp_long;
    int            exp_rpt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    press0_cyc = -1; rel3_cyc = 0; last_hi3 = 0; last_rst_cyc = 0;
    clear_win();
    reset = 1'b1;
    noisy = '0;

    tbl[0] = '{4'b0001, 20, 4'b0001, 1, 0, 0, 0};
    tbl[1] = '{4'b0001, 40, 4'b0001, 0, 0, 1, 0};
    tbl[2] = '{4'b0000, 20, 4'b0000, 0, 1, 0, 0};
    tbl[3] = '{4'b1111, 20, 4'b1111, 4, 0, 0, 0};
    tbl[4] = '{4'b0000, 20, 4'b0000, 0, 4, 0, 0};
    tbl[5] = '{4'b0100, 95, 4'b0100, 1, 0, 1, RPT_IN_HOLD};
    tbl[6] = '{4'b0000, 25, 4'b0000, 0, 1, 0, 0};

    repeat (3) @(negedge clock);
    check("reset_outs", 32'({clean, press, release_pulse, long_press, rpt}), 32'd0);
    reset = 1'b0;

    // table-driven windows
    for (int k = 0; k < 7; k++) begin
      clear_win();
      run_win(tbl[k].nz, tbl[k].cycles);
      check($sformatf("tbl%0d_clean", k), 32'(clean), 32'(tbl[k].exp_clean));
      check($sformatf("tbl%0d_press", k), 32'(win_press), 32'(tbl[k].exp_press));
      check($sformatf("tbl%0d_release", k), 32'(win_rel), 32'(tbl[k].exp_rel));
      check($sformatf("tbl%0d_long", k), 32'(win_long), 32'(tbl[k].exp_long));
      check($sformatf("tbl%0d_rpt", k), 32'(win_rpt), 32'(tbl[k].exp_rpt));
      if (k == 3) check("simultaneous_press", 32'(saw_all_press), 32'd1);
    end

    // glitches on channel 1: one cycle high every six cycles
    clear_win();
    for (int k = 0; k < 34; k++) begin
      run_win(4'b0010, 1);
      run_win(4'b0000, 5);
    end
    check("glitch_press", 32'(win_press), 32'd0);
    check("glitch_clean", 32'(win_clean_or), 32'd0);

    // channel 3 press then release with a 2-cycle bounce while releasing
    run_win(4'b1000, 30);
    clear_win();
    run_win(4'b0000, 5);
    run_win(4'b1000, 2);
    run_win(4'b0000, 30);
    check("bounce_release", 32'(win_rel), 32'd1);
    check("bounce_press", 32'(win_press), 32'd0);
    check("bounce_clean", 32'(clean), 32'd0);
    check_range("bounce_rel_delay", rel3_cyc - last_hi3, 12, 40);

    // reset while channel 0 is held
    run_win(4'b0001, 70);
    clear_win();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("held_reset_outs%0d", k),
            32'({clean, press, release_pulse, long_press, rpt}), 32'd0);
    end
    reset = 1'b0;
    press0_cyc = -1;
    repeat (30) @(negedge clock);
    check("reset_no_release", 32'(win_rel), 32'd0);
    check("reset_repress", 32'(win_press), 32'd1);
    check_range("reset_press_latency", press0_cyc - last_rst_cyc, 12, 16);
    run_win(4'b0000, 25);

    // randomized phase, compared against the model every cycle
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 29) == 0) noisy[i] = ~noisy[i];
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    run_win(4'b0000, 40);
    check("final_clean", 32'(clean), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
